move_sequencer: RTL and testbench

- Turn-level controller for the Connect 4 board storage. It accepts one "place token" request at a time and performs the column-full check, the cell write and the win/draw scan.
- The scan reads neighbouring cells one per cycle through the board memory port, replacing a wide combinational neighbour check.
- Sits between the turn FSM (requester) and the 42-entry board store (single read/write port, 1-cycle read latency). It is the only agent driving that port.

---
 rtl/move_sequencer_pkg.sv | 46 ++++
 rtl/move_sequencer_ray_stepper.sv | 31 +++
 rtl/move_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_move_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/move_sequencer_pkg.sv
// Shared Connect 4 constants, cell encodings, axis step table and sequencer states.
// Used by move_sequencer and ray_stepper.
package c4_pkg;

  localparam int ROWS    = 6;
  localparam int COLS    = 7;
  localparam int WIN_LEN = 4;
  localparam int CELLS   = ROWS * COLS;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1    = 2'b01;
  localparam logic [1:0] P2    = 2'b10;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    CHECK,
    WRITE,
    SEEK,
    ISSUE,
    EVAL,
    DONE
  } state_t;

  // Axis order: horizontal, vertical, diagonal (up-right), anti-diagonal (down-right)
  function automatic logic signed [4:0] axis_drow(input logic [1:0] axis);
    case (axis)
      2'd0:    return 5'sd0;
      2'd1:    return 5'sd1;
      2'd2:    return -5'sd1;
      default: return 5'sd1;
    endcase
  endfunction

  function automatic logic signed [4:0] axis_dcol(input logic [1:0] axis);
    case (axis)
      2'd1:    return 5'sd0;
      default: return 5'sd1;
    endcase
  endfunction

  function automatic logic [5:0] cell_addr(input logic [2:0] row, input logic [2:0] col);
    return 6'(row) * 6'(COLS) + 6'(col);
  endfunction

endpackage

// File: rtl/move_sequencer_ray_stepper.sv
// Combinational neighbour locator: cell reached after 'step' moves along an axis
// in the + (dir=0) or - (dir=1) direction, plus an off-board flag.
module ray_stepper
  import c4_pkg::*;
(
  input  logic [2:0] i_row,
  input  logic [2:0] i_col,
  input  logic [1:0] i_axis,
  input  logic       i_dir,
  input  logic [1:0] i_step,
  output logic [5:0] o_addr,
  output logic       o_off
);

  logic signed [4:0] w_dr, w_dc, w_r, w_c;

  always_comb begin
    w_dr = axis_drow(i_axis) * $signed({3'b000, i_step});
    w_dc = axis_dcol(i_axis) * $signed({3'b000, i_step});
    if (i_dir) begin
      w_dr = -w_dr;
      w_dc = -w_dc;
    end
    w_r    = $signed({2'b00, i_row}) + w_dr;
    w_c    = $signed({2'b00, i_col}) + w_dc;
    o_off  = (w_r < 5'sd0) || (w_r >= $signed(5'(ROWS))) ||
             (w_c < 5'sd0) || (w_c >= $signed(5'(COLS)));
    o_addr = cell_addr(w_r[2:0], w_c[2:0]);
  end

endmodule

// File: rtl/move_sequencer.sv
// Connect 4 move sequencer: board clear, legality check, token write and serial win/draw scan
// through the single board port. Optional win_mask output under `define WIN_MASK_EN.
//
// state | meaning
// CLEAR | write EMPTY to every cell, one per cycle
// IDLE  | wait for a request; also drops busy the cycle after DONE
// CHECK | reject full column, bad column/player, or finished game
// WRITE | store the token, bump height and piece count
// SEEK  | locate first cell of the current ray (ends ray if off-board)
// ISSUE | neighbour address on the board port
// EVAL  | compare read data, pre-locate the next cell of the ray
// DONE  | pulse move_done / move_valid
module move_sequencer
  import c4_pkg::*;
(
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic             move_req,
  input  logic [2:0]       move_col,
  input  logic [1:0]       move_player,
  output logic             move_busy,
  output logic             move_done,
  output logic             move_valid,
  output logic             win,
  output logic             draw,
  output logic [5:0]       board_addr,
  output logic             board_we,
  output logic [1:0]       board_wr_data,
  input  logic [1:0]       board_rd_data
`ifdef WIN_MASK_EN
  ,
  output logic [CELLS-1:0] win_mask
`endif
);

  state_t     r_state;
  logic [5:0] r_clr_cnt, r_addr, r_pieces;
  logic [2:0] r_col, r_row, r_count;
  logic [2:0] r_height [COLS];
  logic [1:0] r_player, r_axis, r_step, r_wr_data;
  logic       r_dir, r_ok, r_busy, r_done, r_valid, r_win, r_draw, r_we;

  logic       w_match, w_ray_end, w_off;
  logic [1:0] w_step;
  logic [2:0] w_end_cnt, w_height;
  logic [5:0] w_addr, w_cell;

  ray_stepper u_ray (
    .i_row  (r_row),
    .i_col  (r_col),
    .i_axis (r_axis),
    .i_dir  (r_dir),
    .i_step (w_step),
    .o_addr (w_addr),
    .o_off  (w_off)
  );

  assign w_height = (r_col < 3'(COLS)) ? r_height[r_col] : 3'(ROWS);
  assign w_cell   = cell_addr(r_row, r_col);

  // EVAL looks one step ahead so a matching ray costs only two cycles per cell
  always_comb begin
    w_match   = (board_rd_data == r_player);
    w_step    = r_step;
    w_end_cnt = r_count;
    w_ray_end = 1'b0;
    if (r_state == EVAL) begin
      w_step    = r_step + 2'd1;
      w_end_cnt = r_count + {2'b00, w_match};
      w_ray_end = !w_match || (r_step == 2'(WIN_LEN - 1)) || w_off;
    end else if (r_state == SEEK) begin
      w_ray_end = w_off;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
      r_win     <= 1'b0;
      r_draw    <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= EMPTY;
      r_pieces  <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_player  <= EMPTY;
      r_axis    <= '0;
      r_dir     <= 1'b0;
      r_step    <= '0;
      r_count   <= '0;
      r_ok      <= 1'b0;
      for (int i = 0; i < COLS; i++) r_height[i] <= '0;
    end else begin
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      case (r_state)
        CLEAR: begin
          if (r_clr_cnt == 6'(CELLS)) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_we      <= 1'b1;
            r_addr    <= r_clr_cnt;
            r_wr_data <= EMPTY;
            r_clr_cnt <= r_clr_cnt + 6'd1;
          end
        end
        IDLE: begin
          if (r_busy) begin
            r_busy <= 1'b0;
          end else if (move_req) begin
            r_col    <= move_col;
            r_player <= move_player;
            r_busy   <= 1'b1;
            r_state  <= CHECK;
          end
        end
        CHECK: begin
          if (w_height == 3'(ROWS) || r_col >= 3'(COLS) ||
              !(r_player == P1 || r_player == P2) || r_win || r_draw) begin
            r_ok    <= 1'b0;
            r_state <= DONE;
          end else begin
            r_row   <= 3'(ROWS - 1) - w_height;
            r_state <= WRITE;
          end
        end
        WRITE: begin
          r_we            <= 1'b1;
          r_addr          <= w_cell;
          r_wr_data       <= r_player;
          r_height[r_col] <= w_height + 3'd1;
          if (r_pieces != 6'(CELLS)) r_pieces <= r_pieces + 6'd1;
          r_axis  <= '0;
          r_dir   <= 1'b0;
          r_step  <= 2'd1;
          r_count <= 3'd1;
          r_ok    <= 1'b1;
          r_state <= SEEK;
        end
        SEEK: begin
          if (!w_off) begin
            r_addr  <= w_addr;
            r_state <= ISSUE;
          end
        end
        ISSUE: r_state <= EVAL;
        EVAL: begin
          if (!w_ray_end) begin
            r_count <= w_end_cnt;
            r_step  <= w_step;
            r_addr  <= w_addr;
            r_state <= ISSUE;
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_valid <= r_ok;
          r_state <= IDLE;
        end
        default: r_state <= CLEAR;
      endcase

      if (w_ray_end) begin
        if (!r_dir) begin
          r_dir   <= 1'b1;
          r_step  <= 2'd1;
          r_count <= w_end_cnt;
          r_state <= SEEK;
        end else if (w_end_cnt >= 3'(WIN_LEN)) begin
          r_win   <= 1'b1;
          r_state <= DONE;
        end else if (r_axis == 2'd3) begin
          if (r_pieces == 6'(CELLS)) r_draw <= 1'b1;
          r_state <= DONE;
        end else begin
          r_axis  <= r_axis + 2'd1;
          r_dir   <= 1'b0;
          r_step  <= 2'd1;
          r_count <= 3'd1;
          r_state <= SEEK;
        end
      end
    end
  end

`ifdef WIN_MASK_EN
  logic [CELLS-1:0] r_mask_axis, r_win_mask, w_mask_now;

  always_comb begin
    w_mask_now = r_mask_axis;
    if (r_state == EVAL && w_match) w_mask_now[r_addr] = 1'b1;
  end

  // Per-axis accumulator restarts from the placed cell at each new axis
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_mask_axis <= '0;
      r_win_mask  <= '0;
    end else if (r_state == WRITE) begin
      r_mask_axis <= CELLS'(1) << w_cell;
    end else if (w_ray_end && r_dir) begin
      if (w_end_cnt >= 3'(WIN_LEN)) r_win_mask <= w_mask_now;
      r_mask_axis <= CELLS'(1) << w_cell;
    end else begin
      r_mask_axis <= w_mask_now;
    end
  end

  assign win_mask = r_win_mask;
`endif

  assign move_busy     = r_busy;
  assign move_done     = r_done;
  assign move_valid    = r_valid;
  assign win           = r_win;
  assign draw          = r_draw;
  assign board_addr    = r_addr;
  assign board_we      = r_we;
  assign board_wr_data = r_wr_data;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: board store model, directed scenarios and random games
// checked against a grid-level Connect 4 reference model.
module tb_move_sequencer;

  logic        clk_sys;
  logic        Reset;
  logic        move_req;
  logic [2:0]  move_col;
  logic [1:0]  move_player;
  logic        move_busy, move_done, move_valid, win, draw;
  logic [5:0]  board_addr;
  logic        board_we;
  logic [1:0]  board_wr_data;
  logic [1:0]  board_rd_data;
`ifdef WIN_MASK_EN
  logic [41:0] win_mask;
`endif

  move_sequencer dut (
    .CLOCK_50      (clk_sys),
    .Reset         (Reset),
    .move_req      (move_req),
    .move_col      (move_col),
    .move_player   (move_player),
    .move_busy     (move_busy),
    .move_done     (move_done),
    .move_valid    (move_valid),
    .win           (win),
    .draw          (draw),
    .board_addr    (board_addr),
    .board_we      (board_we),
    .board_wr_data (board_wr_data),
    .board_rd_data (board_rd_data)
`ifdef WIN_MASK_EN
    ,
    .win_mask      (win_mask)
`endif
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // Board store: single port, 1-cycle read latency
  logic [1:0] mem [64];
  always @(posedge clk_sys) begin
    if (board_we) mem[board_addr] <= board_wr_data;
    board_rd_data <= mem[board_addr];
  end

  int errors = 0;
  int checks = 0;

  // Reference model
  logic [1:0]  grid [6][7];
  int          m_h [7];
  int          m_pieces;
  bit          m_win, m_draw;
  logic [41:0] m_mask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) grid[r][c] = 2'b00;
    for (int c = 0; c < 7; c++) m_h[c] = 0;
    m_pieces = 0;
    m_win    = 0;
    m_draw   = 0;
    m_mask   = '0;
  endtask

  function automatic bit model_win(input int r0, input int c0, input logic [1:0] p,
                                   output logic [41:0] mk);
    int dr, dc, n, r, c;
    for (int a = 0; a < 4; a++) begin
      dr = (a == 0) ? 0 : ((a == 2) ? -1 : 1);
      dc = (a == 1) ? 0 : 1;
      n  = 1;
      mk = '0;
      mk[r0*7+c0] = 1'b1;
      for (int s = -1; s <= 1; s += 2) begin
        for (int k = 1; k < 4; k++) begin
          r = r0 + s*dr*k;
          c = c0 + s*dc*k;
          if (r < 0 || r > 5 || c < 0 || c > 6) break;
          if (grid[r][c] != p) break;
          n++;
          mk[r*7+c] = 1'b1;
        end
      end
      if (n >= 4) return 1'b1;
    end
    mk = '0;
    return 1'b0;
  endfunction

  task automatic clear_check();
    for (int i = 0; i < 42; i++) begin
      @(negedge clk_sys);
      chk("clear_cycle", 64'({board_we, board_addr, board_wr_data, move_busy}),
          64'({1'b1, 6'(i), 2'b00, 1'b1}));
    end
    @(negedge clk_sys);
    chk("clear_end", 64'({move_busy, board_we, move_done, win, draw}), 64'd0);
`ifdef WIN_MASK_EN
    chk("mask_after_reset", 64'(win_mask), 64'd0);
`endif
  endtask

  task automatic reset_board();
    @(negedge clk_sys);
    Reset    = 1'b1;
    move_req = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("reset_outputs", 64'({move_busy, move_done, move_valid, win, draw, board_we}),
        64'(6'b100000));
    Reset = 1'b0;
    clear_check();
    model_clear();
  endtask

  task automatic do_move(input logic [2:0] col, input logic [1:0] pl);
    bit          legal, got, w;
    int          wr_n, lat, row;
    logic [5:0]  wr_a;
    logic [1:0]  wr_d;
    logic [41:0] mk;
    legal = 0;
    row   = 0;
    if (col < 7 && (pl == 2'b01 || pl == 2'b10) && !m_win && !m_draw) legal = (m_h[col] < 6);
    move_req    = 1'b1;
    move_col    = col;
    move_player = pl;
    @(negedge clk_sys);
    chk("busy_on_accept", 64'(move_busy), 64'd1);
    got  = 0;
    wr_n = 0;
    lat  = 0;
    wr_a = '0;
    wr_d = '0;
    for (int c = 1; c <= 60 && !got; c++) begin
      move_req    = 1'($urandom_range(0, 1));
      move_col    = 3'($urandom);
      move_player = 2'($urandom);
      @(negedge clk_sys);
      if (board_we) begin
        wr_n++;
        wr_a = board_addr;
        wr_d = board_wr_data;
      end
      if (move_done) begin
        got = 1;
        lat = c;
        move_req = 1'b0;
      end
    end
    move_req = 1'b0;
    chk("done_seen", 64'(got), 64'd1);
    chk("move_valid", 64'(move_valid), 64'(legal));
    if (legal) begin
      row = 5 - m_h[col];
      grid[row][col] = pl;
      m_h[col]++;
      m_pieces++;
      w = model_win(row, int'(col), pl, mk);
      if (w) begin
        m_win  = 1;
        m_mask = mk;
      end else if (m_pieces == 42) begin
        m_draw = 1;
      end
      chk("write_count", 64'(wr_n), 64'd1);
      chk("write_addr", 64'(wr_a), 64'(row*7 + int'(col)));
      chk("write_data", 64'(wr_d), 64'(pl));
      chk("latency_legal_le52", 64'(lat <= 52), 64'd1);
    end else begin
      chk("write_count", 64'(wr_n), 64'd0);
      chk("latency_illegal", 64'(lat), 64'd2);
    end
    chk("win", 64'(win), 64'(m_win));
    chk("draw", 64'(draw), 64'(m_draw));
`ifdef WIN_MASK_EN
    chk("win_mask", 64'(win_mask), 64'(m_mask));
`endif
    @(negedge clk_sys);
    chk("busy_done_release", 64'({move_busy, move_done}), 64'd0);
  endtask

  task automatic check_board();
    int mism;
    mism = 0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        if (mem[r*7+c] !== grid[r][c]) mism++;
    chk("board_image", 64'(mism), 64'd0);
  endtask

  initial begin
    int v;
    logic [1:0] p;
    Reset       = 1'b1;
    move_req    = 1'b0;
    move_col    = '0;
    move_player = '0;
    model_clear();

    reset_board();

    // Single drop on an empty board: cell 38
    do_move(3'd3, 2'b01);
    chk("first_drop_addr38", 64'(grid[5][3]), 64'(2'b01));

    // Fill column 2, then overflow
    for (int i = 0; i < 7; i++) do_move(3'd2, (i % 2 == 0) ? 2'b10 : 2'b01);
    // Illegal column and player codes
    do_move(3'd7, 2'b01);
    do_move(3'd4, 2'b00);
    do_move(3'd4, 2'b11);
    check_board();

    // Horizontal win, then a rejected request
    reset_board();
    do_move(3'd0, 2'b01); do_move(3'd6, 2'b10);
    do_move(3'd1, 2'b01); do_move(3'd6, 2'b10);
    do_move(3'd2, 2'b01); do_move(3'd6, 2'b10);
    do_move(3'd3, 2'b01);
    chk("horizontal_win", 64'(win), 64'd1);
    do_move(3'd5, 2'b10);
    check_board();

    // Diagonal staircase completed at (2,3)
    reset_board();
    do_move(3'd0, 2'b01);
    do_move(3'd1, 2'b10); do_move(3'd1, 2'b01);
    do_move(3'd2, 2'b10); do_move(3'd2, 2'b10); do_move(3'd2, 2'b01);
    do_move(3'd3, 2'b10); do_move(3'd3, 2'b10); do_move(3'd3, 2'b10);
    do_move(3'd3, 2'b01);
    chk("diagonal_win", 64'(win), 64'd1);
`ifdef WIN_MASK_EN
    chk("diagonal_mask", 64'(win_mask),
        64'((42'd1 << 35) | (42'd1 << 29) | (42'd1 << 23) | (42'd1 << 17)));
`endif
    check_board();

    // Full board with no line of four
    reset_board();
    for (int r = 5; r >= 0; r--)
      for (int c = 0; c < 7; c++)
        do_move(3'(c), (((r / 2) + c) % 2 == 0) ? 2'b01 : 2'b10);
    chk("draw_set", 64'(draw), 64'd1);
    do_move(3'd0, 2'b01);
    check_board();

    // Reset in the middle of a scan
    reset_board();
    do_move(3'd3, 2'b10);
    move_req    = 1'b1;
    move_col    = 3'd3;
    move_player = 2'b01;
    @(negedge clk_sys);
    move_req = 1'b0;
    v = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      if (move_done) v++;
    end
    Reset = 1'b1;
    @(negedge clk_sys);
    if (move_done) v++;
    Reset = 1'b0;
    chk("no_done_on_abort", 64'(v), 64'd0);
    clear_check();
    model_clear();
    do_move(3'd3, 2'b01);
    chk("heights_cleared", 64'(grid[5][3]), 64'(2'b01));
    check_board();

    // Random games
    for (int g = 0; g < 3; g++) begin
      reset_board();
      for (int n = 0; n < 45; n++) begin
        v = $urandom_range(0, 9);
        p = (v == 0) ? 2'b00 : (v == 1) ? 2'b11 : (v < 6) ? 2'b01 : 2'b10;
        do_move(3'($urandom_range(0, 7)), p);
      end
      check_board();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
